// File: rtl/mem_burst_ctrl_if.sv
// Command, write-data and read-data handshake bundle for mem_burst_ctrl.
// The master drives commands and write beats; the slave is the controller.
interface mem_burst_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned LEN_WIDTH  = 5
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  cmd_done;
    logic                  cmd_err;

    modport master (
        output cmd_valid, cmd, cmd_addr, cmd_len, wr_data, wr_valid,
        input  cmd_ready, wr_ready, rd_data, rd_valid, cmd_done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd, cmd_addr, cmd_len, wr_data, wr_valid,
        output cmd_ready, wr_ready, rd_data, rd_valid, cmd_done, cmd_err
    );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst controller in front of a single-port frame RAM: READ, WRITE and FILL bursts
// of up to MAX_BURST words, with range checking and a one-cycle DONE handshake.
module mem_burst_ctrl #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned DEPTH      = 307200,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned LEN_WIDTH  = 5
) (
    input logic             clk,
    input logic             reset,
    mem_burst_ctrl_if.slave bus
);
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [ADDR_WIDTH:0]   addr_ext_t;
    typedef logic [LEN_WIDTH-1:0]  len_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    localparam logic [1:0] OpNop   = 2'b00;
    localparam logic [1:0] OpRead  = 2'b01;
    localparam logic [1:0] OpWrite = 2'b10;

    localparam addr_ext_t DepthLim = addr_ext_t'(DEPTH);
    localparam len_t      MaxLen   = len_t'(MAX_BURST);

    typedef enum logic [2:0] {StIdle, StRead, StWrite, StFill, StDone} state_e;

    state_e state_q;
    addr_t  base_q;
    len_t   len_q;
    len_t   beat_q;
    data_t  fill_q;
    data_t  rd_data_q;
    logic   cmd_ready_q;
    logic   wr_ready_q;
    logic   rd_valid_q;
    logic   cmd_done_q;
    logic   cmd_err_q;

    data_t     mem [DEPTH];
    addr_t     mem_addr;
    data_t     mem_wdata;
    logic      mem_we;
    logic      mem_re;
    addr_ext_t end_addr;
    logic      cmd_ok;
    logic      last_beat;

    // One bit wider than the address so a burst ending exactly at DEPTH is not mistaken for wrap.
    assign end_addr  = addr_ext_t'(bus.cmd_addr) + addr_ext_t'(bus.cmd_len);
    assign cmd_ok    = (bus.cmd_len != '0) && (bus.cmd_len <= MaxLen) && (end_addr <= DepthLim);
    assign last_beat = (beat_q == len_q - len_t'(1));

    // A reset cycle must not let an in-flight burst write one more word.
    always_comb begin
        mem_addr  = base_q + addr_t'(beat_q);
        mem_wdata = bus.wr_data;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (!reset) begin
            unique case (state_q)
                StRead:  mem_re = 1'b1;
                StWrite: mem_we = bus.wr_valid;
                StFill: begin
                    mem_we    = 1'b1;
                    mem_wdata = fill_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (reset) begin
            rd_data_q <= '0;
        end else if (mem_re) begin
            rd_data_q <= mem[mem_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            base_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            fill_q      <= '0;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            cmd_done_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= (state_q == StRead);
            cmd_done_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        base_q      <= bus.cmd_addr;
                        len_q       <= bus.cmd_len;
                        beat_q      <= '0;
                        cmd_ready_q <= 1'b0;
                        if (bus.cmd == 2'b11) begin
                            fill_q <= bus.wr_data;
                        end
                        if (bus.cmd == OpNop) begin
                            state_q    <= StDone;
                            cmd_done_q <= 1'b1;
                        end else if (!cmd_ok) begin
                            state_q    <= StDone;
                            cmd_done_q <= 1'b1;
                            cmd_err_q  <= 1'b1;
                        end else if (bus.cmd == OpRead) begin
                            state_q <= StRead;
                        end else if (bus.cmd == OpWrite) begin
                            state_q    <= StWrite;
                            wr_ready_q <= 1'b1;
                        end else begin
                            state_q <= StFill;
                        end
                    end
                end
                StRead, StFill: begin
                    if (last_beat) begin
                        state_q    <= StDone;
                        cmd_done_q <= 1'b1;
                    end else begin
                        beat_q <= beat_q + len_t'(1);
                    end
                end
                StWrite: begin
                    if (bus.wr_valid) begin
                        if (last_beat) begin
                            state_q    <= StDone;
                            cmd_done_q <= 1'b1;
                            wr_ready_q <= 1'b0;
                        end else begin
                            beat_q <= beat_q + len_t'(1);
                        end
                    end
                end
                StDone: begin
                    state_q     <= StIdle;
                    cmd_ready_q <= 1'b1;
                    beat_q      <= '0;
                end
                default: begin
                    state_q     <= StIdle;
                    cmd_ready_q <= 1'b1;
                    wr_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.cmd_done  = cmd_done_q;
    assign bus.cmd_err   = cmd_err_q;
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl: bursts, fills, range rejects, mid-burst reset
// and command blocking while busy, checked against a sparse memory model.
module tb_mem_burst_ctrl;
    localparam logic [1:0] OpNop   = 2'b00;
    localparam logic [1:0] OpRead  = 2'b01;
    localparam logic [1:0] OpWrite = 2'b10;
    localparam logic [1:0] OpFill  = 2'b11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   hs_cnt = 0;
    logic [11:0] model [int];

    mem_burst_ctrl_if bus ();

    mem_burst_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.cmd_done) done_cnt <= done_cnt + 1;
        if (bus.wr_valid && bus.wr_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [18:0] addr, input logic [4:0] len,
                         input logic [11:0] data);
        chk("cmd_ready_before_issue", bus.cmd_ready, 1);
        bus.cmd       = op;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        bus.wr_data   = data;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_write(input int addr, input int len, input logic [11:0] base, input int gap_at);
        int hs0 = hs_cnt;
        int d0 = done_cnt;
        issue(OpWrite, 19'(addr), 5'(len), 12'h0);
        for (int i = 0; i < len; i++) begin
            if (i == gap_at) begin
                bus.wr_valid = 1'b0;
                repeat (3) begin
                    chk("wr_ready_during_gap", bus.wr_ready, 1);
                    chk("no_done_during_gap", bus.cmd_done, 0);
                    tick();
                end
            end
            chk("wr_ready_in_write", bus.wr_ready, 1);
            bus.wr_valid = 1'b1;
            bus.wr_data  = base + 12'(i);
            model[addr + i] = base + 12'(i);
            tick();
        end
        bus.wr_valid = 1'b0;
        chk("write_done", bus.cmd_done, 1);
        chk("write_err", bus.cmd_err, 0);
        chk("wr_ready_in_done", bus.wr_ready, 0);
        tick();
        chk("write_handshakes", hs_cnt - hs0, len);
        chk("write_done_count", done_cnt - d0, 1);
    endtask

    task automatic do_read(input int addr, input int len);
        issue(OpRead, 19'(addr), 5'(len), 12'h0);
        chk("read_first_rd_valid", bus.rd_valid, 0);
        chk("read_cmd_ready_busy", bus.cmd_ready, 0);
        tick();
        for (int i = 0; i < len; i++) begin
            chk("read_rd_valid", bus.rd_valid, 1);
            chk("read_rd_data", bus.rd_data, model[addr + i]);
            chk("read_done_on_last", bus.cmd_done, (i == len - 1) ? 1 : 0);
            chk("read_err", bus.cmd_err, 0);
            tick();
        end
        chk("read_rd_valid_after", bus.rd_valid, 0);
        chk("read_rd_data_hold", bus.rd_data, model[addr + len - 1]);
        chk("read_idle_after", bus.cmd_ready, 1);
    endtask

    task automatic do_fill(input int addr, input int len, input logic [11:0] val);
        int hs0 = hs_cnt;
        issue(OpFill, 19'(addr), 5'(len), val);
        bus.wr_valid = 1'b1;
        bus.wr_data  = ~val;
        for (int i = 0; i < len; i++) begin
            chk("fill_wr_ready", bus.wr_ready, 0);
            chk("fill_no_done", bus.cmd_done, 0);
            model[addr + i] = val;
            tick();
        end
        chk("fill_done", bus.cmd_done, 1);
        chk("fill_err", bus.cmd_err, 0);
        bus.wr_valid = 1'b0;
        tick();
        chk("fill_handshakes", hs_cnt - hs0, 0);
    endtask

    task automatic do_reject(input logic [1:0] op, input int addr, input int len,
                             input logic [11:0] data);
        int hs0 = hs_cnt;
        bus.wr_valid = 1'b1;
        issue(op, 19'(addr), 5'(len), data);
        chk("reject_done", bus.cmd_done, 1);
        chk("reject_err", bus.cmd_err, 1);
        chk("reject_rd_valid", bus.rd_valid, 0);
        chk("reject_wr_ready", bus.wr_ready, 0);
        tick();
        bus.wr_valid = 1'b0;
        chk("reject_done_pulse", bus.cmd_done, 0);
        chk("reject_idle", bus.cmd_ready, 1);
        chk("reject_rd_valid_after", bus.rd_valid, 0);
        chk("reject_handshakes", hs_cnt - hs0, 0);
    endtask

    initial begin
        int d0;
        bus.cmd_valid = 1'b1;
        bus.cmd       = OpRead;
        bus.cmd_addr  = '0;
        bus.cmd_len   = 5'd1;
        bus.wr_data   = '0;
        bus.wr_valid  = 1'b0;

        // Reset state, with a command offered during reset.
        tick();
        tick();
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_cmd_done", bus.cmd_done, 0);
        chk("rst_cmd_err", bus.cmd_err, 0);
        bus.cmd_valid = 1'b0;
        reset = 1'b0;
        tick();
        chk("rst_cmd_not_taken_ready", bus.cmd_ready, 1);
        chk("rst_cmd_not_taken_valid", bus.rd_valid, 0);
        chk("rst_cmd_not_taken_done", bus.cmd_done, 0);

        issue(OpNop, 19'd0, 5'd0, 12'h0);
        chk("nop_done", bus.cmd_done, 1);
        chk("nop_err", bus.cmd_err, 0);
        tick();
        chk("nop_back_idle", bus.cmd_ready, 1);

        do_write(100, 4, 12'h001, 2);
        do_read(100, 4);

        do_write(16, 1, 12'h777, -1);
        do_fill(0, 16, 12'hABC);
        do_read(0, 16);
        do_read(16, 1);

        do_reject(OpRead, 307199, 2, 12'h0);
        do_reject(OpRead, 0, 0, 12'h0);
        do_reject(OpWrite, 100, 17, 12'hFFF);
        do_read(100, 4);

        do_fill(307184, 16, 12'h5A5);
        do_reject(OpFill, 307190, 16, 12'h111);
        do_read(307184, 16);

        // Reset after two beats of an eight-beat write.
        do_write(200, 8, 12'h100, -1);
        issue(OpWrite, 19'd200, 5'd8, 12'h0);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 12'h200;
        tick();
        bus.wr_data  = 12'h201;
        tick();
        model[200] = 12'h200;
        model[201] = 12'h201;
        d0 = done_cnt;
        bus.wr_data = 12'h2FF;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.wr_valid = 1'b0;
        chk("abort_cmd_ready", bus.cmd_ready, 1);
        chk("abort_wr_ready", bus.wr_ready, 0);
        chk("abort_cmd_done", bus.cmd_done, 0);
        repeat (3) tick();
        chk("abort_no_done_count", done_cnt - d0, 0);
        do_read(200, 8);

        // A different command held on cmd_valid through a whole READ burst.
        bus.cmd       = OpRead;
        bus.cmd_addr  = 19'd100;
        bus.cmd_len   = 5'd4;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd      = OpWrite;
        bus.cmd_addr = 19'd300;
        bus.cmd_len  = 5'd1;
        bus.wr_data  = 12'h333;
        chk("busy_cmd_ready", bus.cmd_ready, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("busy_rd_valid", bus.rd_valid, 1);
            chk("busy_rd_data", bus.rd_data, model[100 + i]);
            chk("busy_cmd_ready_low", bus.cmd_ready, 0);
            chk("busy_wr_ready_low", bus.wr_ready, 0);
            tick();
        end
        chk("held_cmd_idle_ready", bus.cmd_ready, 1);
        chk("held_cmd_not_taken", bus.wr_ready, 0);
        tick();
        chk("held_cmd_taken", bus.wr_ready, 1);
        chk("held_cmd_busy", bus.cmd_ready, 0);
        bus.cmd_valid = 1'b0;
        bus.wr_valid  = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
        model[300] = 12'h333;
        chk("held_write_done", bus.cmd_done, 1);
        tick();
        do_read(300, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
